// File: rtl/store_buffer_pkg.sv
// Shared types and constants for the store buffer: entry layout, word-index slice
// and byte-lane geometry used by both the queue and the forwarding merge.
package store_buffer_pkg;

  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned NUM_LANES = 4;
  localparam int unsigned LANE_W    = DATA_W / NUM_LANES;

  // dm aliases on a 1024-word window, so only addr[11:2] identifies a word.
  localparam int unsigned WORD_HI = 11;
  localparam int unsigned WORD_LO = 2;
  localparam int unsigned WORD_W  = WORD_HI - WORD_LO + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              sb;
    logic [ADDR_W-1:0] pc;
  } sbEntry_t;

endpackage

// File: rtl/sb_fwd_merge.sv
// Combinational store-to-load forwarding: walks the age-ordered entries oldest to
// newest so that younger stores override older ones lane by lane.
module sb_fwd_merge
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                 ldValid,
  input  logic [WORD_W-1:0]    ldWord,
  input  sbEntry_t [DEPTH-1:0] entries,   // index 0 is the oldest entry
  input  logic [DEPTH-1:0]     entValid,
  output logic [NUM_LANES-1:0] fwdMask,
  output logic [DATA_W-1:0]    fwdData
);

  always_comb begin
    fwdMask = '0;
    fwdData = '0;
    if (ldValid) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (entValid[k] && (entries[k].addr[WORD_HI:WORD_LO] == ldWord)) begin
          if (entries[k].sb) begin
            for (int b = 0; b < NUM_LANES; b++) begin
              if (entries[k].addr[WORD_LO-1:0] == b[WORD_LO-1:0]) begin
                fwdMask[b]                 = 1'b1;
                fwdData[b*LANE_W +: LANE_W] = entries[k].data[LANE_W-1:0];
              end
            end
          end else begin
            fwdMask = '1;
            fwdData = entries[k].data;
          end
        end
      end
    end
  end

  // PC and the aliased upper address bits play no part in matching.
  logic unusedBits;
  always_comb begin
    unusedBits = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      unusedBits = unusedBits ^ (^entries[k].pc) ^ (^entries[k].addr[ADDR_W-1:WORD_HI+1]);
    end
  end

endmodule

// File: rtl/store_buffer.sv
// In-order store FIFO in front of the dm write port; drains one store per cycle
// whenever no load owns the port and forwards buffered bytes to loads.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 st_valid,
  input  logic [ADDR_W-1:0]    st_addr,
  input  logic [DATA_W-1:0]    st_data,
  input  logic                 st_sb,
  input  logic [ADDR_W-1:0]    st_pc,
  output logic                 st_ready,
  input  logic                 ld_valid,
  input  logic [ADDR_W-1:0]    ld_addr,
  output logic [NUM_LANES-1:0] fwd_mask,
  output logic [DATA_W-1:0]    fwd_data,
  output logic [ADDR_W-1:0]    dm_addr,
  output logic [DATA_W-1:0]    dm_data,
  output logic                 dm_wr,
  output logic                 dm_sb,
  output logic [ADDR_W-1:0]    dm_pc,
  output logic                 empty
);

  localparam logic [PTR_W:0]   FullCount = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CountOne  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PtrOne    = PTR_W'(1);

  sbEntry_t [DEPTH-1:0] memQ;
  logic [PTR_W-1:0]     headQ, tailQ;
  logic [PTR_W:0]       countQ;

  logic                 full, push, pop;
  sbEntry_t             newEntry, headEntry;
  sbEntry_t [DEPTH-1:0] ageOrdered;
  logic [DEPTH-1:0]     ageValid;

  assign full     = (countQ == FullCount);
  assign empty    = (countQ == '0);
  // A same-cycle drain does not free a slot for the incoming store.
  assign st_ready = !full;
  assign push     = st_valid && !full;
  assign pop      = !empty && !ld_valid;
  assign dm_wr    = pop;

  always_comb begin
    newEntry = '{addr: st_addr, data: st_data, sb: st_sb, pc: st_pc};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      memQ   <= '0;
      headQ  <= '0;
      tailQ  <= '0;
      countQ <= '0;
    end else begin
      if (push) begin
        memQ[tailQ] <= newEntry;
        tailQ       <= tailQ + PtrOne;
      end
      if (pop) begin
        headQ <= headQ + PtrOne;
      end
      if (push && !pop) begin
        countQ <= countQ + CountOne;
      end else if (pop && !push) begin
        countQ <= countQ - CountOne;
      end
    end
  end

  // Rotate the ring so the merge sees entries in program order.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      ageOrdered[k] = memQ[headQ + PTR_W'(k)];
      ageValid[k]   = ((PTR_W+1)'(k) < countQ);
    end
  end

  always_comb begin
    headEntry = empty ? '0 : memQ[headQ];
    dm_data   = headEntry.data;
    dm_sb     = headEntry.sb;
    dm_pc     = headEntry.pc;
    dm_addr   = ld_valid ? ld_addr : headEntry.addr;
  end

  sb_fwd_merge #(
    .DEPTH (DEPTH)
  ) u_fwd_merge (
    .ldValid  (ld_valid),
    .ldWord   (ld_addr[WORD_HI:WORD_LO]),
    .entries  (ageOrdered),
    .entValid (ageValid),
    .fwdMask  (fwd_mask),
    .fwdData  (fwd_data)
  );

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: a scoreboard of expected dm writes is filled
// as stores are accepted and drained by a monitor as the DUT writes dm.
module tb_store_buffer;

  logic        clk;
  logic        reset;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_sb;
  logic [31:0] st_pc;
  logic        st_ready;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic [3:0]  fwd_mask;
  logic [31:0] fwd_data;
  logic [31:0] dm_addr;
  logic [31:0] dm_data;
  logic        dm_wr;
  logic        dm_sb;
  logic [31:0] dm_pc;
  logic        empty;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        sb;
    logic [31:0] pc;
  } expWrite_t;

  expWrite_t expQ[$];
  expWrite_t monExp;
  int        nAssert = 0;
  int        nFail   = 0;

  store_buffer #(
    .DEPTH (4),
    .PTR_W (2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .st_valid (st_valid),
    .st_addr  (st_addr),
    .st_data  (st_data),
    .st_sb    (st_sb),
    .st_pc    (st_pc),
    .st_ready (st_ready),
    .ld_valid (ld_valid),
    .ld_addr  (ld_addr),
    .fwd_mask (fwd_mask),
    .fwd_data (fwd_data),
    .dm_addr  (dm_addr),
    .dm_data  (dm_data),
    .dm_wr    (dm_wr),
    .dm_sb    (dm_sb),
    .dm_pc    (dm_pc),
    .empty    (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // accept is the bench's own knowledge of whether the buffer has room.
  task automatic driveStore(input logic [31:0] a, input logic [31:0] d, input logic sb,
                            input logic [31:0] pc, input bit accept);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    st_sb    = sb;
    st_pc    = pc;
    if (accept) expQ.push_back('{addr: a, data: d, sb: sb, pc: pc});
  endtask

  task automatic idleStore();
    st_valid = 1'b0;
    st_addr  = '0;
    st_data  = '0;
    st_sb    = 1'b0;
    st_pc    = '0;
  endtask

  // Scoreboard: every dm write must match the oldest outstanding accepted store.
  always @(negedge clk) begin
    if (dm_wr === 1'b1) begin
      nAssert++;
      assert (expQ.size() != 0) else begin
        nFail++;
        $error("FAIL dm_unexpected_write: observed write to 0x%08h expected no write", dm_addr);
      end
      if (expQ.size() != 0) begin
        monExp = expQ.pop_front();
        check("sb_dm_addr", dm_addr, monExp.addr);
        check("sb_dm_data", dm_data, monExp.data);
        check("sb_dm_sb", 32'(dm_sb), 32'(monExp.sb));
        check("sb_dm_pc", dm_pc, monExp.pc);
      end
    end
  end

  initial begin
    reset    = 1'b1;
    ld_valid = 1'b1;
    ld_addr  = 32'h0000_0ABC;
    idleStore();

    // Reset state
    @(negedge clk);
    check("rst_st_ready", 32'(st_ready), 1);
    check("rst_empty", 32'(empty), 1);
    check("rst_dm_wr", 32'(dm_wr), 0);
    check("rst_dm_data", dm_data, 0);
    check("rst_dm_sb", 32'(dm_sb), 0);
    check("rst_dm_pc", dm_pc, 0);
    check("rst_fwd_mask", 32'(fwd_mask), 0);
    check("rst_fwd_data", fwd_data, 0);
    check("rst_dm_addr_ld", dm_addr, 32'h0000_0ABC);
    ld_valid = 1'b0;
    #1;
    check("rst_dm_addr_head", dm_addr, 0);
    nextCycle();
    reset = 1'b0;

    // Single word store drains on the next cycle
    driveStore(32'h10, 32'h1122_3344, 1'b0, 32'h100, 1'b1);
    @(negedge clk);
    check("t1_empty_before", 32'(empty), 1);
    check("t1_dm_wr_before", 32'(dm_wr), 0);
    nextCycle();
    idleStore();
    @(negedge clk);
    check("t1_dm_wr", 32'(dm_wr), 1);
    check("t1_dm_addr", dm_addr, 32'h10);
    check("t1_dm_data", dm_data, 32'h1122_3344);
    check("t1_dm_sb", 32'(dm_sb), 0);
    nextCycle();
    @(negedge clk);
    check("t1_empty_after", 32'(empty), 1);
    check("t1_dm_wr_after", 32'(dm_wr), 0);

    // Fill under a held load, overflow attempt, then in-order drain
    ld_valid = 1'b1;
    ld_addr  = 32'h14;
    for (int i = 0; i < 4; i++) begin
      nextCycle();
      driveStore(32'h40 + 32'(4 * i), 32'hA000_0000 + 32'(i), 1'b0, 32'h200 + 32'(4 * i), 1'b1);
      @(negedge clk);
      check("t2_fill_ready", 32'(st_ready), 1);
      check("t2_fill_dm_wr", 32'(dm_wr), 0);
      check("t2_fill_dm_addr", dm_addr, 32'h14);
    end
    nextCycle();
    driveStore(32'h50, 32'hDEAD_0005, 1'b0, 32'h210, 1'b0);
    @(negedge clk);
    check("t2_full_ready", 32'(st_ready), 0);
    check("t2_full_dm_wr", 32'(dm_wr), 0);
    nextCycle();
    idleStore();
    ld_valid = 1'b0;
    @(negedge clk);
    check("t2_still_full", 32'(st_ready), 0);
    check("t2_drain0_wr", 32'(dm_wr), 1);
    check("t2_drain0_addr", dm_addr, 32'h40);
    for (int j = 1; j < 4; j++) begin
      nextCycle();
      @(negedge clk);
      check("t2_drain_wr", 32'(dm_wr), 1);
      check("t2_drain_addr", dm_addr, 32'h40 + 32'(4 * j));
    end
    nextCycle();
    @(negedge clk);
    check("t2_empty", 32'(empty), 1);

    // Word then byte forwarding with newer-overrides-older
    nextCycle();
    ld_valid = 1'b1;
    ld_addr  = 32'h20;
    driveStore(32'h20, 32'hAABB_CCDD, 1'b0, 32'h300, 1'b1);
    @(negedge clk);
    check("t3_same_cycle_mask", 32'(fwd_mask), 0);
    check("t3_same_cycle_data", fwd_data, 0);
    nextCycle();
    driveStore(32'h22, 32'h0000_0055, 1'b1, 32'h304, 1'b1);
    @(negedge clk);
    check("t3_word_mask", 32'(fwd_mask), 32'hF);
    check("t3_word_data", fwd_data, 32'hAABB_CCDD);
    nextCycle();
    idleStore();
    @(negedge clk);
    check("t3_merge_mask", 32'(fwd_mask), 32'hF);
    check("t3_merge_data", fwd_data, 32'hAA55_CCDD);
    nextCycle();
    ld_valid = 1'b0;
    @(negedge clk);
    check("t3_noload_mask", 32'(fwd_mask), 0);
    check("t3_noload_data", fwd_data, 0);
    check("t3_drain_sb0", 32'(dm_sb), 0);
    nextCycle();
    @(negedge clk);
    check("t3_drain_sb1", 32'(dm_sb), 1);
    check("t3_drain_addr1", dm_addr, 32'h22);
    nextCycle();
    @(negedge clk);
    check("t3_empty", 32'(empty), 1);

    // Lone byte store, aliased and non-matching loads
    nextCycle();
    ld_valid = 1'b1;
    ld_addr  = 32'h30;
    driveStore(32'h31, 32'hDEAD_BE7F, 1'b1, 32'h400, 1'b1);
    @(negedge clk);
    check("t4_same_cycle_mask", 32'(fwd_mask), 0);
    nextCycle();
    idleStore();
    @(negedge clk);
    check("t4_byte_mask", 32'(fwd_mask), 32'h2);
    check("t4_byte_data", fwd_data, 32'h0000_7F00);
    ld_addr = 32'h1030;
    #1;
    check("t4_alias_mask", 32'(fwd_mask), 32'h2);
    check("t4_alias_data", fwd_data, 32'h0000_7F00);
    ld_addr = 32'h34;
    #1;
    check("t4_miss_mask", 32'(fwd_mask), 0);
    check("t4_miss_data", fwd_data, 0);
    nextCycle();
    ld_valid = 1'b0;
    @(negedge clk);
    check("t4_drain_data", dm_data, 32'hDEAD_BE7F);
    nextCycle();
    @(negedge clk);
    check("t4_empty", 32'(empty), 1);

    // Full buffer: drain with a blocked push, then push+pop with tail wrap
    ld_valid = 1'b1;
    ld_addr  = 32'h14;
    for (int i = 0; i < 4; i++) begin
      nextCycle();
      driveStore(32'h60 + 32'(4 * i), 32'hB000_0000 + 32'(i), 1'b0, 32'h500 + 32'(4 * i), 1'b1);
    end
    nextCycle();
    ld_valid = 1'b0;
    driveStore(32'h70, 32'hEEEE_EEEE, 1'b0, 32'h540, 1'b0);
    @(negedge clk);
    check("t5_full_pop_ready", 32'(st_ready), 0);
    check("t5_full_pop_wr", 32'(dm_wr), 1);
    check("t5_full_pop_addr", dm_addr, 32'h60);
    nextCycle();
    driveStore(32'h74, 32'hF000_0001, 1'b1, 32'h544, 1'b1);
    @(negedge clk);
    check("t5_pushpop_ready", 32'(st_ready), 1);
    check("t5_pushpop_addr", dm_addr, 32'h64);
    nextCycle();
    driveStore(32'h78, 32'hF000_0002, 1'b0, 32'h548, 1'b1);
    @(negedge clk);
    check("t5_pushpop2_ready", 32'(st_ready), 1);
    check("t5_pushpop2_addr", dm_addr, 32'h68);
    nextCycle();
    idleStore();
    @(negedge clk);
    check("t5_drain3_addr", dm_addr, 32'h6C);
    nextCycle();
    @(negedge clk);
    check("t5_drain_wrapF", dm_addr, 32'h74);
    nextCycle();
    @(negedge clk);
    check("t5_drain_wrapG", dm_addr, 32'h78);
    check("t5_not_empty", 32'(empty), 0);
    nextCycle();
    @(negedge clk);
    check("t5_empty", 32'(empty), 1);

    // Asynchronous reset in the middle of a drain
    ld_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      driveStore(32'h80 + 32'(4 * i), 32'hC000_0000 + 32'(i), 1'b0, 32'h600 + 32'(4 * i), 1'b1);
    end
    nextCycle();
    idleStore();
    ld_valid = 1'b0;
    @(negedge clk);
    check("t6_drain_wr", 32'(dm_wr), 1);
    check("t6_drain_addr", dm_addr, 32'h80);
    #2;
    reset = 1'b1;
    expQ.delete();
    #1;
    check("t6_rst_empty", 32'(empty), 1);
    check("t6_rst_dm_wr", 32'(dm_wr), 0);
    check("t6_rst_ready", 32'(st_ready), 1);
    check("t6_rst_dm_data", dm_data, 0);
    check("t6_rst_dm_pc", dm_pc, 0);
    nextCycle();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      nextCycle();
      @(negedge clk);
      check("t6_post_empty", 32'(empty), 1);
      check("t6_post_dm_wr", 32'(dm_wr), 0);
    end

    check("final_scoreboard_empty", 32'(expQ.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
